// File: rtl/det_pkg.sv
// det_pkg: shared types and default sizing for the HOG/SVM result stream.
package det_pkg;

    // Default slide-window geometry shared with the classifier.
    localparam int DET_SW_W   = 11;
    localparam int DET_NUM_SW = 1200;

    // Frame accumulator states.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } det_state_e;

    // One frame summary as held in the report slot.
    typedef struct packed {
        logic [DET_SW_W:0]   hits;
        logic [DET_SW_W-1:0] first_id;
        logic                person;
        logic                err;
    } det_report_t;

endpackage

// File: rtl/led_hold_timer.sv
// led_hold_timer: keeps the LED lit for HOLD_CYC clocks after the last load.
// A hold time of 0 is treated as 1 so that a load always produces a visible pulse.
module led_hold_timer #(
    parameter int HOLD_W   = 25,
    parameter int HOLD_CYC = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    output logic o_led
);

    localparam logic [HOLD_W-1:0] LOAD_VAL = (HOLD_CYC == 0) ? HOLD_W'(1) : HOLD_W'(HOLD_CYC);

    logic [HOLD_W-1:0] r_cnt;

    // Reload on request, otherwise count down to zero and stop there.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_led = (r_cnt != '0);

endmodule

// File: rtl/det_result_ctrl.sv
// det_result_ctrl: frame-level controller for the classifier result stream.
// Checks window sequencing, accumulates hits per frame, publishes one summary
// per frame through a single-entry valid/ready slot and drives the person LED.
// Build option DET_LED_IMMEDIATE_EN: when defined, every accepted person beat
// also (re)starts the LED hold, instead of only person frame summaries.
//
// state | meaning
// IDLE  | waiting for a window-0 beat to open a frame
// SCAN  | frame open, accumulating beats until the last window id
module det_result_ctrl
    import det_pkg::*;
#(
    parameter int SW_W     = DET_SW_W,
    parameter int NUM_SW   = DET_NUM_SW,
    parameter int MIN_HITS = 1,
    parameter int HOLD_W   = 25,
    parameter int HOLD_CYC = 25000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid,
    input  logic            i_is_person,
    input  logic [SW_W-1:0] i_sw_id,
    output logic            rpt_valid,
    input  logic            rpt_ready,
    output logic [SW_W:0]   rpt_hits,
    output logic [SW_W-1:0] rpt_first_id,
    output logic            rpt_person,
    output logic            rpt_err,
    output logic            rpt_overrun,
    output logic            led
);

    localparam logic [SW_W-1:0] LAST_ID    = SW_W'(NUM_SW - 1);
    localparam logic [SW_W:0]   HITS_MAX   = '1;
    localparam logic [SW_W:0]   MIN_HITS_C = (SW_W + 1)'(MIN_HITS);

    det_state_e      r_state, w_state_nxt;
    logic [SW_W:0]   r_hits, w_hits_nxt;
    logic [SW_W-1:0] r_first_id, w_first_id_nxt;
    logic            r_has_first, w_has_first_nxt;
    logic            r_err, w_err_nxt;
    logic [SW_W-1:0] r_expected, w_expected_nxt;
    logic            w_take;
    logic            w_end;
    logic            w_person;
    logic            w_led_load;

    det_report_t     r_rpt;
    logic            r_rpt_valid;
    logic            r_overrun;
    logic            w_handshake;

    // Next-state and accumulator update for the current beat.
    // A window-0 beat always (re)opens a frame; in SCAN that means the old
    // frame is abandoned and the new one starts out flagged as erroneous.
    always_comb begin
        w_state_nxt     = r_state;
        w_hits_nxt      = r_hits;
        w_first_id_nxt  = r_first_id;
        w_has_first_nxt = r_has_first;
        w_err_nxt       = r_err;
        w_expected_nxt  = r_expected;
        w_end           = 1'b0;
        w_take          = i_valid && ((r_state == SCAN) || (i_sw_id == '0));

        if (w_take) begin
            if (i_sw_id == '0) begin
                w_hits_nxt      = '0;
                w_first_id_nxt  = '0;
                w_has_first_nxt = 1'b0;
                w_err_nxt       = (r_state == SCAN);
            end else if (i_sw_id != r_expected) begin
                w_err_nxt = 1'b1;
            end

            if (i_is_person && (w_hits_nxt != HITS_MAX)) begin
                w_hits_nxt = w_hits_nxt + 1'b1;
            end
            if (i_is_person && !w_has_first_nxt) begin
                w_first_id_nxt  = i_sw_id;
                w_has_first_nxt = 1'b1;
            end

            w_expected_nxt = i_sw_id + 1'b1;

            if (i_sw_id == LAST_ID) begin
                w_end       = 1'b1;
                w_state_nxt = IDLE;
            end else begin
                w_state_nxt = SCAN;
            end
        end
    end

    assign w_person = (w_hits_nxt >= MIN_HITS_C);

    // State and accumulator registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_hits      <= '0;
            r_first_id  <= '0;
            r_has_first <= 1'b0;
            r_err       <= 1'b0;
            r_expected  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_hits      <= w_hits_nxt;
            r_first_id  <= w_first_id_nxt;
            r_has_first <= w_has_first_nxt;
            r_err       <= w_err_nxt;
            r_expected  <= w_expected_nxt;
        end
    end

    assign w_handshake = r_rpt_valid && rpt_ready;

    // Single-entry report slot; a frame end always wins over a handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rpt       <= '0;
            r_rpt_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_end) begin
                r_rpt.hits     <= (DET_SW_W + 1)'(w_hits_nxt);
                r_rpt.first_id <= DET_SW_W'(w_first_id_nxt);
                r_rpt.person   <= w_person;
                r_rpt.err      <= w_err_nxt;
                r_rpt_valid    <= 1'b1;
            end else if (w_handshake) begin
                r_rpt_valid <= 1'b0;
            end

            if (w_handshake) begin
                r_overrun <= 1'b0;
            end else if (w_end && r_rpt_valid) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // LED hold restarts on person summaries (and optionally on person beats).
`ifdef DET_LED_IMMEDIATE_EN
    assign w_led_load = (w_end && w_person) || (w_take && i_is_person);
`else
    assign w_led_load = w_end && w_person;
`endif

    led_hold_timer #(
        .HOLD_W   (HOLD_W),
        .HOLD_CYC (HOLD_CYC)
    ) u_led_hold_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_led_load),
        .o_led  (led)
    );

    assign rpt_valid    = r_rpt_valid;
    assign rpt_hits     = (SW_W + 1)'(r_rpt.hits);
    assign rpt_first_id = SW_W'(r_rpt.first_id);
    assign rpt_person   = r_rpt.person;
    assign rpt_err      = r_rpt.err;
    assign rpt_overrun  = r_overrun;

endmodule
